dma_controller: RTL and testbench

- Memory-to-memory DMA engine; sits directly downstream of the CPU command port.
- Takes a two-beat command from the CPU (source + length, then destination), requests the shared memory bus, and copies the block through an internal burst buffer.
- Raises a done interrupt, which drives the CPU's rx_interrupt.
- Tristate bus glue lives at top level; this block uses unidirectional ports.

---
 rtl/dma_controller.sv | 171 +++++++++++++++++
 tb/tb_dma_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : dma_controller
// Brief    : Memory-to-memory DMA engine, copies blocks in bursts through a
//            small internal buffer; two-beat command, done/err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module dma_controller #(
    parameter int SZ        = 8,
    parameter int WSZ       = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    input  logic           cmd_w_notr,
    input  logic [SZ-1:0]  cmd_addr,
    input  logic [WSZ-1:0] cmd_data,
    output logic           bus_req,
    input  logic           bus_grant,
    output logic [SZ-1:0]  mem_addr,
    output logic           mem_re,
    output logic           mem_we,
    output logic [WSZ-1:0] mem_wdata,
    input  logic [WSZ-1:0] mem_rdata,
    output logic           busy,
    output logic           done_irq,
    output logic           err
);

    localparam int c_aw = $clog2(BUF_DEPTH);
    localparam int c_cw = c_aw + 1;

    localparam logic [SZ-1:0]   c_depth_sz = SZ'(BUF_DEPTH);
    localparam logic [c_cw-1:0] c_depth_cw = c_cw'(BUF_DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [SZ-1:0]   c_addr_one = SZ'(1);
    localparam logic [SZ-1:0]   c_zero_sz  = '0;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_got_src = 3'd1;
    localparam logic [2:0] c_st_req     = 3'd2;
    localparam logic [2:0] c_st_rd      = 3'd3;
    localparam logic [2:0] c_st_wr      = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    logic [2:0]      r_state;
    logic [SZ-1:0]   r_src;
    logic [SZ-1:0]   r_dst;
    logic [SZ-1:0]   r_remaining;
    logic [c_cw-1:0] r_issue_cnt;
    logic [c_cw-1:0] r_cap_cnt;
    logic [c_cw-1:0] r_wr_cnt;
    logic            r_rd_pend;
    logic            r_err;
    logic [WSZ-1:0]  r_buf [BUF_DEPTH];

    logic            w_beat;
    logic            w_beat_rejected;
    logic [c_cw-1:0] w_burst;
    logic            w_re;
    logic            w_we;
    logic            w_last_cap;
    logic            w_last_wr;
    logic [SZ-1:0]   w_remaining_after;

    assign w_beat          = cmd_valid & cmd_w_notr;
    assign w_beat_rejected = w_beat && (r_state == c_st_req || r_state == c_st_rd ||
                                        r_state == c_st_wr  || r_state == c_st_done);

    // Burst size always tracks what is left, so no separate burst register is needed.
    assign w_burst = (r_remaining >= c_depth_sz) ? c_depth_cw : r_remaining[c_cw-1:0];
    assign w_remaining_after = r_remaining - SZ'(w_burst);

    // Strobes are gated by the grant in the same cycle: losing the bus must
    // suppress the access immediately, not one cycle later.
    assign w_re = (r_state == c_st_rd) && bus_grant && (r_issue_cnt < w_burst);
    assign w_we = (r_state == c_st_wr) && bus_grant && (r_wr_cnt < w_burst);

    assign w_last_cap = r_rd_pend && (r_cap_cnt == (w_burst - c_cnt_one));
    assign w_last_wr  = w_we && (r_wr_cnt == (w_burst - c_cnt_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_rd_pend   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err     <= w_beat_rejected;
            r_rd_pend <= w_re;
            case (r_state)
                c_st_idle: begin
                    if (w_beat) begin
                        r_src       <= cmd_addr;
                        r_remaining <= cmd_data[SZ-1:0];
                        r_state     <= c_st_got_src;
                    end
                end
                c_st_got_src: begin
                    if (w_beat) begin
                        r_dst   <= cmd_addr;
                        r_state <= (r_remaining == c_zero_sz) ? c_st_done : c_st_req;
                    end
                end
                c_st_req: begin
                    if (bus_grant) begin
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                        r_wr_cnt    <= '0;
                        r_state     <= c_st_rd;
                    end
                end
                c_st_rd: begin
                    if (w_re) begin
                        r_src       <= r_src + c_addr_one;
                        r_issue_cnt <= r_issue_cnt + c_cnt_one;
                    end
                    if (r_rd_pend) begin
                        r_cap_cnt <= r_cap_cnt + c_cnt_one;
                    end
                    if (w_last_cap) begin
                        r_wr_cnt <= '0;
                        r_state  <= c_st_wr;
                    end
                end
                c_st_wr: begin
                    if (w_we) begin
                        r_dst    <= r_dst + c_addr_one;
                        r_wr_cnt <= r_wr_cnt + c_cnt_one;
                    end
                    if (w_last_wr) begin
                        r_remaining <= w_remaining_after;
                        r_issue_cnt <= '0;
                        r_cap_cnt   <= '0;
                        r_state     <= (w_remaining_after == c_zero_sz) ? c_st_done : c_st_rd;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Buffer contents are don't-care after reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (r_rd_pend && (r_state == c_st_rd)) begin
            r_buf[r_cap_cnt[c_aw-1:0]] <= mem_rdata;
        end
    end

    assign bus_req   = (r_state == c_st_req) || (r_state == c_st_rd) || (r_state == c_st_wr);
    assign busy      = (r_state != c_st_idle) && (r_state != c_st_done);
    assign done_irq  = (r_state == c_st_done);
    assign err       = r_err;
    assign mem_re    = w_re;
    assign mem_we    = w_we;
    assign mem_addr  = w_re ? r_src : (w_we ? r_dst : '0);
    assign mem_wdata = w_we ? r_buf[r_wr_cnt[c_aw-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_controller
// Brief    : Directed self-checking bench for dma_controller with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_w_notr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       bus_req;
    logic       bus_grant;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done_irq;
    logic       err;

    always #5 clk = ~clk;

    dma_controller #(.SZ(8), .WSZ(8), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_w_notr(cmd_w_notr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done_irq(done_irq), .err(err)
    );

    // RAM model; read data is only valid the cycle after a read strobe
    logic [7:0] ram [256];
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_re ? ram[mem_addr] : 8'hEE;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] rd_log = '0;
    logic [63:0] wr_log = '0;
    logic [31:0] op_log = '0;
    int rd_n = 0, wr_n = 0, done_n = 0, err_n = 0, req_n = 0, bad_n = 0, done_cyc = 0;
    always @(negedge clk) begin
        if (mem_re) begin rd_log <= {rd_log[55:0], mem_addr}; rd_n <= rd_n + 1; end
        if (mem_we) begin wr_log <= {wr_log[55:0], mem_addr}; wr_n <= wr_n + 1; end
        if (mem_re || mem_we) op_log <= {op_log[30:0], mem_we};
        if (done_irq) begin done_n <= done_n + 1; done_cyc <= cyc; end
        if (err) err_n <= err_n + 1;
        if (bus_req) req_n <= req_n + 1;
        if ((mem_re && mem_we) || ((mem_re || mem_we) && !bus_grant)) bad_n <= bad_n + 1;
    end

    int tests = 0;
    int fails = 0;
    int rd0, wr0, done0, err0, req0, bad0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic snap();
        rd0 = rd_n; wr0 = wr_n; done0 = done_n; err0 = err_n; req0 = req_n; bad0 = bad_n;
    endtask

    task automatic send_cmd(input logic [7:0] src, input logic [7:0] len,
                            input logic [7:0] dst, output int e1);
        cmd_valid = 1'b1; cmd_w_notr = 1'b1; cmd_addr = src; cmd_data = len;
        tick();
        cmd_addr = dst; cmd_data = 8'h00;
        tick();
        e1 = cyc;
        cmd_valid = 1'b0; cmd_w_notr = 1'b0; cmd_addr = 8'h00;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_n != done0) begin ok = 1'b1; break; end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_w_notr = 1'b0; cmd_addr = '0; cmd_data = '0;
        bus_grant = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus_req, mem_re, mem_we, busy, done_irq, err, mem_addr, mem_wdata} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus_req, mem_re, mem_we, busy, done_irq, err, mem_addr, mem_wdata});
        end
        tick();
    endtask

    task automatic test_basic();
        int e1; bit ok;
        bus_grant = 1'b1;
        load(8'd5, 8'hA1); load(8'd6, 8'hB2); load(8'd7, 8'hC3);
        for (int i = 12; i < 16; i++) load(8'(i), 8'h55);
        snap();
        send_cmd(8'd5, 8'd3, 8'd12, e1);
        tests++;
        if ({busy, bus_req, mem_re} !== 3'b110) begin
            fails++; $display("FAIL basic_after_beats: got %b expected 110", {busy, bus_req, mem_re});
        end
        wait_done(60, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_timeout: got no done_irq expected one"); end
        tests++;
        if (rd_n - rd0 != 3 || rd_log[23:0] !== 24'h050607) begin
            fails++; $display("FAIL basic_reads: got %0d reads %h expected 3 reads 050607", rd_n - rd0, rd_log[23:0]);
        end
        tests++;
        if (wr_n - wr0 != 3 || wr_log[23:0] !== 24'h0C0D0E) begin
            fails++; $display("FAIL basic_writes: got %0d writes %h expected 3 writes 0c0d0e", wr_n - wr0, wr_log[23:0]);
        end
        tests++;
        if ({ram[12], ram[13], ram[14], ram[15]} !== 32'hA1B2C355) begin
            fails++; $display("FAIL basic_ram: got %h expected a1b2c355", {ram[12], ram[13], ram[14], ram[15]});
        end
        tests++;
        if (done_n - done0 != 1) begin
            fails++; $display("FAIL basic_done_count: got %0d expected 1", done_n - done0);
        end
        tests++;
        if (done_cyc != e1 + 8) begin
            fails++; $display("FAIL basic_latency: got %0d cycles expected 8", done_cyc - e1);
        end
        tests++;
        if (busy !== 1'b0 || bad_n != bad0) begin
            fails++; $display("FAIL basic_idle: got busy=%b bad=%0d expected busy=0 bad=0", busy, bad_n - bad0);
        end
    endtask

    task automatic test_multi_burst();
        int e1; bit ok;
        load(8'd20, 8'h11); load(8'd21, 8'h22); load(8'd22, 8'h33); load(8'd23, 8'h44); load(8'd24, 8'h55);
        for (int i = 40; i < 45; i++) load(8'(i), 8'h00);
        snap();
        send_cmd(8'd20, 8'd5, 8'd40, e1);
        wait_done(80, ok);
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL multi_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if (rd_n - rd0 != 5 || rd_log[39:0] !== 40'h1415161718) begin
            fails++; $display("FAIL multi_reads: got %0d reads %h expected 5 reads 1415161718", rd_n - rd0, rd_log[39:0]);
        end
        tests++;
        if (wr_n - wr0 != 5 || wr_log[39:0] !== 40'h28292A2B2C) begin
            fails++; $display("FAIL multi_writes: got %0d writes %h expected 5 writes 28292a2b2c", wr_n - wr0, wr_log[39:0]);
        end
        tests++;
        if (op_log[9:0] !== 10'b0000_1111_01) begin
            fails++; $display("FAIL multi_order: got %b expected 0000111101", op_log[9:0]);
        end
        tests++;
        if ({ram[40], ram[41], ram[42], ram[43], ram[44]} !== 40'h1122334455) begin
            fails++; $display("FAIL multi_ram: got %h expected 1122334455", {ram[40], ram[41], ram[42], ram[43], ram[44]});
        end
    endtask

    task automatic test_wrap();
        int e1; bit ok;
        load(8'd254, 8'h9A); load(8'd255, 8'hBC); load(8'd0, 8'hDE);
        for (int i = 100; i < 103; i++) load(8'(i), 8'h00);
        snap();
        send_cmd(8'd254, 8'd3, 8'd100, e1);
        wait_done(60, ok);
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL wrap_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if (rd_n - rd0 != 3 || rd_log[23:0] !== 24'hFEFF00) begin
            fails++; $display("FAIL wrap_reads: got %0d reads %h expected 3 reads feff00", rd_n - rd0, rd_log[23:0]);
        end
        tests++;
        if ({ram[100], ram[101], ram[102]} !== 24'h9ABCDE) begin
            fails++; $display("FAIL wrap_ram: got %h expected 9abcde", {ram[100], ram[101], ram[102]});
        end
    endtask

    task automatic test_grant_loss();
        int e1; bit ok; bit seen;
        load(8'd60, 8'hD0); load(8'd61, 8'hD1); load(8'd62, 8'hD2); load(8'd63, 8'hD3);
        for (int i = 80; i < 84; i++) load(8'(i), 8'h00);
        bus_grant = 1'b0;
        snap();
        send_cmd(8'd60, 8'd4, 8'd80, e1);
        tick(); tick();
        tests++;
        if ({bus_req, mem_re} !== 2'b10) begin
            fails++; $display("FAIL grant_wait: got req/re %b expected 10", {bus_req, mem_re});
        end
        bus_grant = 1'b1;
        tick();
        tick();
        bus_grant = 1'b0;
        repeat (3) tick();
        bus_grant = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (mem_we) seen = 1'b1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL grant_first_write: got no write expected one"); end
        tick();
        bus_grant = 1'b0;
        repeat (3) tick();
        bus_grant = 1'b1;
        wait_done(60, ok);
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL grant_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if (rd_n - rd0 != 4 || rd_log[31:0] !== 32'h3C3D3E3F) begin
            fails++; $display("FAIL grant_reads: got %0d reads %h expected 4 reads 3c3d3e3f", rd_n - rd0, rd_log[31:0]);
        end
        tests++;
        if (wr_n - wr0 != 4 || wr_log[31:0] !== 32'h50515253) begin
            fails++; $display("FAIL grant_writes: got %0d writes %h expected 4 writes 50515253", wr_n - wr0, wr_log[31:0]);
        end
        tests++;
        if ({ram[80], ram[81], ram[82], ram[83]} !== 32'hD0D1D2D3 || bad_n != bad0) begin
            fails++; $display("FAIL grant_ram: got %h bad=%0d expected d0d1d2d3 bad=0",
                              {ram[80], ram[81], ram[82], ram[83]}, bad_n - bad0);
        end
    endtask

    task automatic test_zero_len();
        int e1; bit ok;
        snap();
        send_cmd(8'd30, 8'd0, 8'd31, e1);
        wait_done(20, ok);
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL zero_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if (done_cyc != e1) begin
            fails++; $display("FAIL zero_latency: got %0d cycles expected 0", done_cyc - e1);
        end
        tests++;
        if (rd_n != rd0 || wr_n != wr0 || req_n != req0) begin
            fails++; $display("FAIL zero_no_bus: got re=%0d we=%0d req=%0d expected 0 0 0",
                              rd_n - rd0, wr_n - wr0, req_n - req0);
        end
    endtask

    task automatic test_err_beat();
        int e1; bit ok;
        load(8'd120, 8'h3A); load(8'd121, 8'h4B); load(8'd122, 8'h5C);
        for (int i = 130; i < 133; i++) load(8'(i), 8'h00);
        snap();
        send_cmd(8'd120, 8'd3, 8'd130, e1);
        tick();
        cmd_valid = 1'b1; cmd_w_notr = 1'b0; cmd_addr = 8'd200; cmd_data = 8'd9;
        tick();
        cmd_w_notr = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_w_notr = 1'b0;
        wait_done(60, ok);
        tests++;
        if (err_n - err0 != 1) begin
            fails++; $display("FAIL err_pulse: got %0d cycles expected 1", err_n - err0);
        end
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL err_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if (rd_n - rd0 != 3 || rd_log[23:0] !== 24'h78797A) begin
            fails++; $display("FAIL err_reads: got %0d reads %h expected 3 reads 78797a", rd_n - rd0, rd_log[23:0]);
        end
        tests++;
        if ({ram[130], ram[131], ram[132]} !== 24'h3A4B5C) begin
            fails++; $display("FAIL err_ram: got %h expected 3a4b5c", {ram[130], ram[131], ram[132]});
        end
    endtask

    task automatic test_reset_mid();
        int e1; bit ok; bit seen;
        load(8'd140, 8'h81); load(8'd141, 8'h82); load(8'd142, 8'h83); load(8'd143, 8'h84);
        for (int i = 150; i < 154; i++) load(8'(i), 8'h77);
        snap();
        send_cmd(8'd140, 8'd4, 8'd150, e1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (mem_we) seen = 1'b1;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (!seen || {bus_req, mem_re, mem_we, busy, done_irq, err, mem_addr, mem_wdata} !== 22'd0) begin
            fails++; $display("FAIL midreset_outputs: got write_seen=%b outs=%b expected 1 and all zero", seen,
                              {bus_req, mem_re, mem_we, busy, done_irq, err, mem_addr, mem_wdata});
        end
        repeat (5) tick();
        tests++;
        if (done_n != done0) begin
            fails++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_n - done0);
        end
        tests++;
        if ({ram[152], ram[153]} !== 16'h7777) begin
            fails++; $display("FAIL midreset_ram: got %h expected 7777", {ram[152], ram[153]});
        end
        load(8'd160, 8'hE1); load(8'd161, 8'hE2);
        load(8'd170, 8'h00); load(8'd171, 8'h00);
        snap();
        send_cmd(8'd160, 8'd2, 8'd170, e1);
        wait_done(40, ok);
        tests++;
        if (!ok || done_n - done0 != 1) begin
            fails++; $display("FAIL midreset_new_done: got %0d pulses expected 1", done_n - done0);
        end
        tests++;
        if ({ram[170], ram[171]} !== 16'hE1E2) begin
            fails++; $display("FAIL midreset_new_ram: got %h expected e1e2", {ram[170], ram[171]});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_burst();
        test_wrap();
        test_grant_loss();
        test_zero_len();
        test_err_beat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
